// File: rtl/hazard_unit_mc_pkg.sv
// Shared types for the pipeline hazard controller: register addresses,
// forwarding mux selects and the MDU occupancy state encoding.
package hazard_unit_mc_pkg;

    localparam int REG_AW_DEF = 5;

    typedef logic [REG_AW_DEF-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/hz_perf_counters.sv
// Three free-running event counters with a shared synchronous clear that
// wins over any same-cycle increment; all wrap modulo 2^CNT_W.
module hz_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             incStall,
    input  logic             incFlush,
    input  logic             incMdu,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushEvents,
    output logic [CNT_W-1:0] mduOps
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // counter samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles <= '0;
            flushEvents <= '0;
            mduOps      <= '0;
        end else if (clr) begin
            stallCycles <= '0;
            flushEvents <= '0;
            mduOps      <= '0;
        end else begin
            if (incStall) stallCycles <= stallCycles + CNT_W'(1);
            if (incFlush) flushEvents <= flushEvents + CNT_W'(1);
            if (incMdu)   mduOps      <= mduOps + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// multi-cycle MDU occupancy FSM and performance counters.
module hazard_unit_mc
    import hazard_unit_mc_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReadE,
    input  logic              PCSrcE,
    input  logic              MduOpE,
    input  logic              PerfClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MduBusy,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushEvents,
    output logic [CNT_W-1:0]  MduOps
);

    localparam bit         MULTI_CYCLE = (MDU_LAT > 1);
    localparam logic [3:0] LOAD_CNT    = MULTI_CYCLE ? 4'(MDU_LAT - 2) : 4'd0;

    mdu_state_t state, stateNext;
    logic [3:0] cnt, cntNext;
    logic       mduDone;
    logic       lwStall;
    logic       mduStall;

    // M is the younger producer, so it always wins over W.
    function automatic fwd_sel_t fwdSel(input logic [REG_AW-1:0] rs);
        if (RegWriteM && RdM != '0 && RdM == rs)      return FWD_M;
        else if (RegWriteW && RdW != '0 && RdW == rs) return FWD_W;
        else                                          return FWD_RF;
    endfunction

    assign ForwardAE = fwdSel(Rs1E);
    assign ForwardBE = fwdSel(Rs2E);

    assign lwStall  = MemReadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    assign mduStall = MduOpE && MULTI_CYCLE && (state == IDLE || cnt != 4'd0);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        mduDone   = 1'b0;
        if (MULTI_CYCLE) begin
            case (state)
                IDLE: if (MduOpE) begin
                    stateNext = BUSY;
                    cntNext   = LOAD_CNT;
                end
                BUSY: if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    stateNext = IDLE;
                    mduDone   = 1'b1;
                end
            endcase
        end else begin
            mduDone = MduOpE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // The held MDU op must survive its stall window, hence the FlushE mask.
    assign StallF  = lwStall | mduStall;
    assign StallD  = lwStall | mduStall;
    assign StallE  = mduStall;
    assign FlushD  = PCSrcE;
    assign FlushE  = (lwStall | PCSrcE) & ~mduStall;
    assign FlushM  = mduStall;
    assign MduBusy = (state == BUSY);

    hz_perf_counters #(
        .CNT_W(CNT_W)
    ) uCounters (
        .clk        (clk),
        .reset      (reset),
        .clr        (PerfClr),
        .incStall   (StallF),
        .incFlush   (PCSrcE),
        .incMdu     (mduDone),
        .stallCycles(StallCycles),
        .flushEvents(FlushEvents),
        .mduOps     (MduOps)
    );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_unit_mc;

    localparam int AW = 5;
    localparam int CW = 32;

    typedef enum int {
        SIG_CTRL, SIG_FWDA, SIG_FWDB, SIG_STALLCNT, SIG_FLUSHCNT, SIG_MDUOPS,
        SIG_CTRL1, SIG_FWD1, SIG_STALLCNT1, SIG_FLUSHCNT1, SIG_MDUOPS1
    } sig_t;

    typedef struct {
        sig_t        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    // Ctrl packing: {StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy}
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_LW    = 7'b1100100;
    localparam logic [6:0] C_BR    = 7'b0001100;
    localparam logic [6:0] C_MDU0  = 7'b1110010;
    localparam logic [6:0] C_MDUB  = 7'b1110011;
    localparam logic [6:0] C_MDUR  = 7'b0000001;
    localparam logic [6:0] C_LWBR  = 7'b1101100;
    localparam logic [6:0] BB[8]   = '{C_MDU0, C_MDUB, C_MDUB, C_MDUR,
                                       C_MDU0, C_MDUB, C_MDUB, C_MDUR};

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, MemReadE, PCSrcE, MduOpE, PerfClr;

    logic [1:0]    ForwardAE, ForwardBE, ForwardAE1, ForwardBE1;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy;
    logic          StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, MduBusy1;
    logic [CW-1:0] StallCycles, FlushEvents, MduOps;
    logic [CW-1:0] StallCycles1, FlushEvents1, MduOps1;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(AW), .MDU_LAT(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
        .PCSrcE(PCSrcE), .MduOpE(MduOpE), .PerfClr(PerfClr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MduBusy(MduBusy),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents), .MduOps(MduOps)
    );

    hazard_unit_mc #(.REG_AW(AW), .MDU_LAT(1), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
        .PCSrcE(PCSrcE), .MduOpE(MduOpE), .PerfClr(PerfClr),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushM(FlushM1), .MduBusy(MduBusy1),
        .StallCycles(StallCycles1), .FlushEvents(FlushEvents1), .MduOps(MduOps1)
    );

    function automatic logic [31:0] actual(input sig_t s);
        case (s)
            SIG_CTRL:      return 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy});
            SIG_FWDA:      return 32'(ForwardAE);
            SIG_FWDB:      return 32'(ForwardBE);
            SIG_STALLCNT:  return StallCycles;
            SIG_FLUSHCNT:  return FlushEvents;
            SIG_MDUOPS:    return MduOps;
            SIG_CTRL1:     return 32'({StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, MduBusy1});
            SIG_FWD1:      return 32'({ForwardAE1, ForwardBE1});
            SIG_STALLCNT1: return StallCycles1;
            SIG_FLUSHCNT1: return FlushEvents1;
            SIG_MDUOPS1:   return MduOps1;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: everything queued during a cycle is compared at its negedge.
    always @(negedge clk) begin
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, actual(e.sel), e.val);
        end
    end

    task automatic pushExp(input sig_t s, input logic [31:0] v, input string n);
        sb.push_back('{s, v, n});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadE = 1'b0;
        PCSrcE = 1'b0; MduOpE = 1'b0; PerfClr = 1'b0;
    endtask

    task automatic perfClear();
        step(); clearIn(); PerfClr = 1'b1;
        step(); PerfClr = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clearIn();

        // Reset state
        step();
        pushExp(SIG_CTRL, 32'(C_IDLE), "reset_ctrl");
        pushExp(SIG_STALLCNT, 0, "reset_stallcnt");
        pushExp(SIG_MDUOPS, 0, "reset_mduops");
        step(); reset = 1'b1;

        // Forwarding priority
        step();
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
        Rs1E = 5'd5; Rs2E = 5'd5;
        pushExp(SIG_FWDA, 32'd2, "fwdA_m_wins");
        pushExp(SIG_FWDB, 32'd2, "fwdB_m_wins");
        pushExp(SIG_FWD1, 32'hA, "fwd_lat1_m");
        step(); RdM = 5'd0;
        pushExp(SIG_FWDA, 32'd1, "fwdA_w_rdm0");
        pushExp(SIG_FWDB, 32'd1, "fwdB_w_rdm0");
        step(); Rs1E = 5'd0; RdW = 5'd0;
        pushExp(SIG_FWDA, 32'd0, "fwdA_rf_x0");
        pushExp(SIG_FWDB, 32'd0, "fwdB_rf_rdw0");
        step(); RdM = 5'd9; RegWriteM = 1'b0; RdW = 5'd9; Rs2E = 5'd9;
        pushExp(SIG_FWDB, 32'd1, "fwdB_w_no_regwritem");

        // Load-use stall
        perfClear();
        MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        pushExp(SIG_CTRL, 32'(C_LW), "lw_ctrl");
        step(); clearIn();
        pushExp(SIG_CTRL, 32'(C_IDLE), "lw_release");
        pushExp(SIG_STALLCNT, 32'd1, "lw_stallcnt");
        step(); MemReadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        pushExp(SIG_CTRL, 32'(C_IDLE), "lw_rde0_nostall");
        step(); clearIn();
        pushExp(SIG_STALLCNT, 32'd1, "lw_rde0_stallcnt");

        // Branch flush
        step(); PCSrcE = 1'b1;
        pushExp(SIG_CTRL, 32'(C_BR), "br_ctrl");
        step(); clearIn();
        pushExp(SIG_CTRL, 32'(C_IDLE), "br_release");
        pushExp(SIG_FLUSHCNT, 32'd1, "br_flushcnt");
        pushExp(SIG_STALLCNT, 32'd1, "br_no_extra_stall");

        // Single MDU op, latency 4
        perfClear();
        MduOpE = 1'b1; Rs1E = 5'd3; RdW = 5'd3; RegWriteW = 1'b1;
        pushExp(SIG_CTRL, 32'(C_MDU0), "mdu_c1");
        pushExp(SIG_FWDA, 32'd1, "mdu_fwd_first_cycle");
        step(); pushExp(SIG_CTRL, 32'(C_MDUB), "mdu_c2");
        step(); pushExp(SIG_CTRL, 32'(C_MDUB), "mdu_c3");
        step(); pushExp(SIG_CTRL, 32'(C_MDUR), "mdu_c4_release");
        step(); clearIn();
        pushExp(SIG_CTRL, 32'(C_IDLE), "mdu_idle_after");
        pushExp(SIG_MDUOPS, 32'd1, "mdu_ops1");
        pushExp(SIG_STALLCNT, 32'd3, "mdu_stallcnt3");

        // Back-to-back MDU ops on both latencies
        perfClear();
        for (int i = 0; i < 8; i++) begin
            if (i != 0) step();
            MduOpE = 1'b1;
            pushExp(SIG_CTRL, 32'(BB[i]), $sformatf("b2b_c%0d", i + 1));
            pushExp(SIG_CTRL1, 32'(C_IDLE), $sformatf("lat1_c%0d", i + 1));
        end
        step(); clearIn();
        pushExp(SIG_MDUOPS, 32'd2, "b2b_mduops");
        pushExp(SIG_STALLCNT, 32'd6, "b2b_stallcnt");
        pushExp(SIG_MDUOPS1, 32'd8, "lat1_mduops");
        pushExp(SIG_STALLCNT1, 32'd0, "lat1_stallcnt");
        pushExp(SIG_FLUSHCNT1, 32'd0, "lat1_flushcnt");

        // Asynchronous reset in the middle of an op (BUSY, cnt=1)
        step(); MduOpE = 1'b1;
        step();
        step(); reset = 1'b0;
        pushExp(SIG_CTRL, 32'(C_MDU0), "rst_mid_busy_ctrl");
        pushExp(SIG_STALLCNT, 32'd0, "rst_stallcnt");
        pushExp(SIG_MDUOPS, 32'd0, "rst_mduops");
        step(); reset = 1'b1;
        pushExp(SIG_CTRL, 32'(C_MDU0), "post_rst_c1");
        step(); pushExp(SIG_CTRL, 32'(C_MDUB), "post_rst_c2");
        step(); pushExp(SIG_CTRL, 32'(C_MDUB), "post_rst_c3");
        step(); pushExp(SIG_CTRL, 32'(C_MDUR), "post_rst_c4");
        step(); clearIn();
        pushExp(SIG_STALLCNT, 32'd3, "post_rst_stallcnt");
        pushExp(SIG_MDUOPS, 32'd1, "post_rst_mduops");

        // PerfClr beats same-cycle increments
        step();
        PerfClr = 1'b1; MemReadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
        pushExp(SIG_CTRL, 32'(C_LWBR), "clr_cycle_ctrl");
        step(); clearIn();
        pushExp(SIG_STALLCNT, 32'd0, "clr_beats_stall");
        pushExp(SIG_FLUSHCNT, 32'd0, "clr_beats_flush");
        pushExp(SIG_MDUOPS, 32'd0, "clr_mduops");

        step();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
